// File: rtl/multicycle_sequencer.sv
// Decode-stage sequencer for multi-cycle instructions (CALL/RET/RTI/LDM) and
// interrupt entry; overrides the combinational control unit while busy.
module multicycle_sequencer #(
  parameter int PC_W      = 32,
  parameter int STK_W     = 16,
  parameter int FLUSH_CYC = 2,
  parameter int IDX_W     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [2:0]       op_class,
  input  logic             bubble,
  input  logic             hold,
  input  logic             irq,
  output logic             busy,
  output logic             accept,
  output logic             push_en,
  output logic             pop_en,
  output logic [IDX_W-1:0] word_idx,
  output logic             pc_load,
  output logic             vector_sel,
  output logic             save_ccr,
  output logic             restore_ccr,
  output logic             imm_phase,
  output logic             flush,
  output logic             irq_ack
);

  localparam int WORDS = PC_W / STK_W;
  localparam int FW    = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [FW-1:0]    FLOAD    = FW'((FLUSH_CYC > 0) ? FLUSH_CYC - 1 : 0);

  localparam logic [2:0] OP_CALL = 3'd1;
  localparam logic [2:0] OP_RET  = 3'd2;
  localparam logic [2:0] OP_RTI  = 3'd3;
  localparam logic [2:0] OP_LDM  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP,
    S_IMM,
    S_FLUSH
  } state_t;

  typedef enum logic [1:0] {
    M_CALL,
    M_INT,
    M_RET,
    M_RTI
  } mode_t;

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic             irq_pend_q, irq_pend_d;

  logic is_idle;
  logic take_irq;
  logic take_instr;
  logic last_word;
  logic mc_class;

  always_comb begin
    is_idle    = (state_q == S_IDLE);
    last_word  = (cnt_q == LAST_IDX);
    mc_class   = (op_class == OP_CALL) || (op_class == OP_RET) ||
                 (op_class == OP_RTI)  || (op_class == OP_LDM);
    take_irq   = is_idle && !hold && (irq_pend_q || irq);
    take_instr = is_idle && !hold && !take_irq && !bubble && instr_valid && mc_class;
  end

  // Next-state; everything except irq_pend freezes while hold is high.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    fcnt_d     = fcnt_q;
    irq_pend_d = (irq_pend_q || irq) && !take_irq;

    if (!hold) begin
      case (state_q)
        S_IDLE: begin
          if (take_irq) begin
            mode_d  = M_INT;
            state_d = S_PUSH;
            cnt_d   = '0;
          end else if (take_instr) begin
            cnt_d = '0;
            case (op_class)
              OP_CALL: begin
                mode_d  = M_CALL;
                state_d = S_PUSH;
              end
              OP_RET: begin
                mode_d  = M_RET;
                state_d = S_POP;
              end
              OP_RTI: begin
                mode_d  = M_RTI;
                state_d = S_POP;
              end
              default: state_d = S_IMM;
            endcase
          end
        end
        S_PUSH, S_POP: begin
          if (last_word) begin
            cnt_d = '0;
            if (FLUSH_CYC == 0) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_FLUSH;
              fcnt_d  = FLOAD;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_IMM: state_d = S_IDLE;
        S_FLUSH: begin
          if (fcnt_q == '0) begin
            state_d = S_IDLE;
          end else begin
            fcnt_d = fcnt_q - 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= M_CALL;
      cnt_q      <= '0;
      fcnt_q     <= '0;
      irq_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      fcnt_q     <= fcnt_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  // IDLE-cycle decodes are qualified by rst_n so every output is 0 in reset.
  always_comb begin
    busy        = !is_idle;
    flush       = (state_q == S_FLUSH);
    push_en     = (state_q == S_PUSH) && !hold;
    pop_en      = (state_q == S_POP) && !hold;
    pc_load     = ((state_q == S_PUSH) || (state_q == S_POP)) && last_word && !hold;
    vector_sel  = pc_load && (mode_q == M_INT);
    restore_ccr = (state_q == S_POP) && last_word && !hold && (mode_q == M_RTI);
    imm_phase   = (state_q == S_IMM) && !hold;
    accept      = take_instr && rst_n;
    irq_ack     = take_irq && rst_n;
    save_ccr    = take_irq && rst_n;
    word_idx    = '0;
    if (state_q == S_PUSH) begin
      word_idx = cnt_q;
    end else if (state_q == S_POP) begin
      word_idx = LAST_IDX - cnt_q;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: a default instance (2 words, 2 flush cycles) and a
// 48-bit instance with no flush; directed per-cycle expected output vectors.
module tb_multicycle_sequencer;

  typedef struct packed {
    logic       busy;
    logic       acc;
    logic       push;
    logic       pop;
    logic [1:0] idx;
    logic       pcl;
    logic       vs;
    logic       sv;
    logic       rs;
    logic       imm;
    logic       fl;
    logic       ack;
  } ov_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_na, iv_a, bub_a, hld_a, irq_a;
  logic [2:0] op_a;
  logic       busy_a, acc_a, push_a, pop_a, pcl_a, vs_a, sv_a, rs_a, imm_a, fl_a, ack_a;
  logic [0:0] idx_a;

  logic       rst_nb, iv_b, bub_b, hld_b, irq_b;
  logic [2:0] op_b;
  logic       busy_b, acc_b, push_b, pop_b, pcl_b, vs_b, sv_b, rs_b, imm_b, fl_b, ack_b;
  logic [1:0] idx_b;

  multicycle_sequencer #(.PC_W(32), .STK_W(16), .FLUSH_CYC(2), .IDX_W(1)) dut_a (
    .clk(clk), .rst_n(rst_na), .instr_valid(iv_a), .op_class(op_a), .bubble(bub_a),
    .hold(hld_a), .irq(irq_a), .busy(busy_a), .accept(acc_a), .push_en(push_a),
    .pop_en(pop_a), .word_idx(idx_a), .pc_load(pcl_a), .vector_sel(vs_a),
    .save_ccr(sv_a), .restore_ccr(rs_a), .imm_phase(imm_a), .flush(fl_a), .irq_ack(ack_a)
  );

  multicycle_sequencer #(.PC_W(48), .STK_W(16), .FLUSH_CYC(0), .IDX_W(2)) dut_b (
    .clk(clk), .rst_n(rst_nb), .instr_valid(iv_b), .op_class(op_b), .bubble(bub_b),
    .hold(hld_b), .irq(irq_b), .busy(busy_b), .accept(acc_b), .push_en(push_b),
    .pop_en(pop_b), .word_idx(idx_b), .pc_load(pcl_b), .vector_sel(vs_b),
    .save_ccr(sv_b), .restore_ccr(rs_b), .imm_phase(imm_b), .flush(fl_b), .irq_ack(ack_b)
  );

  ov_t qa[$];
  ov_t qb[$];
  int  ida[$];
  int  idb[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  step_no = 0;

  function automatic ov_t E(input logic bsy, acc, psh, pop, input logic [1:0] ix,
                            input logic pcl, vs, sv, rs, im, fl, ak);
    ov_t o;
    o = {bsy, acc, psh, pop, ix, pcl, vs, sv, rs, im, fl, ak};
    return o;
  endfunction

  // Monitor: pops one expected vector per cycle for each instance with pending work.
  always @(negedge clk) begin
    ov_t exp_v, act_v;
    int  id;
    if (qa.size() > 0) begin
      exp_v = qa.pop_front();
      id    = ida.pop_front();
      act_v = {busy_a, acc_a, push_a, pop_a, 1'b0, idx_a, pcl_a, vs_a, sv_a, rs_a, imm_a, fl_a, ack_a};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL dutA step %0d: got %b want %b (busy acc push pop idx pcl vs sv rs imm fl ack)",
                 id, act_v, exp_v);
      end
    end
    if (qb.size() > 0) begin
      exp_v = qb.pop_front();
      id    = idb.pop_front();
      act_v = {busy_b, acc_b, push_b, pop_b, idx_b, pcl_b, vs_b, sv_b, rs_b, imm_b, fl_b, ack_b};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL dutB step %0d: got %b want %b (busy acc push pop idx pcl vs sv rs imm fl ack)",
                 id, act_v, exp_v);
      end
    end
  end

  task automatic sa(input logic iv, input logic [2:0] op, input logic bub, hld, irqv, input ov_t e);
    iv_a = iv; op_a = op; bub_a = bub; hld_a = hld; irq_a = irqv;
    qa.push_back(e);
    ida.push_back(step_no);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic sb(input logic rst, iv, input logic [2:0] op, input ov_t e);
    if (!rst) rst_nb = 1'b0;
    iv_b = iv; op_b = op;
    qb.push_back(e);
    idb.push_back(step_no);
    step_no++;
    @(posedge clk);
    #1;
    rst_nb = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ov_t I0, ACC, ACK, PU0, PU1L, PU1V, PO1, PO0L, PO0R, FL, HPO1, IMMV;
    ov_t BPU1, BPU2L, BPO2, BPO1;
    I0   = '0;
    ACC  = E(0,1,0,0,0,0,0,0,0,0,0,0);
    ACK  = E(0,0,0,0,0,0,0,1,0,0,0,1);
    PU0  = E(1,0,1,0,0,0,0,0,0,0,0,0);
    PU1L = E(1,0,1,0,1,1,0,0,0,0,0,0);
    PU1V = E(1,0,1,0,1,1,1,0,0,0,0,0);
    PO1  = E(1,0,0,1,1,0,0,0,0,0,0,0);
    PO0L = E(1,0,0,1,0,1,0,0,0,0,0,0);
    PO0R = E(1,0,0,1,0,1,0,0,1,0,0,0);
    FL   = E(1,0,0,0,0,0,0,0,0,0,1,0);
    HPO1 = E(1,0,0,0,1,0,0,0,0,0,0,0);
    IMMV = E(1,0,0,0,0,0,0,0,0,1,0,0);
    BPU1  = E(1,0,1,0,1,0,0,0,0,0,0,0);
    BPU2L = E(1,0,1,0,2,1,0,0,0,0,0,0);
    BPO2  = E(1,0,0,1,2,0,0,0,0,0,0,0);
    BPO1  = E(1,0,0,1,1,0,0,0,0,0,0,0);

    rst_na = 1'b0; iv_a = 1'b0; op_a = 3'd0; bub_a = 1'b0; hld_a = 1'b0; irq_a = 1'b0;
    rst_nb = 1'b0; iv_b = 1'b0; op_b = 3'd0; bub_b = 1'b0; hld_b = 1'b0; irq_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_na = 1'b1;
    rst_nb = 1'b1;

    // reset state
    sa(0,0,0,0,0, I0);
    // CALL
    sa(1,1,0,0,0, ACC); sa(0,0,0,0,0, PU0); sa(0,0,0,0,0, PU1L);
    sa(0,0,0,0,0, FL);  sa(0,0,0,0,0, FL);  sa(0,0,0,0,0, I0);
    // RTI
    sa(1,3,0,0,0, ACC); sa(0,0,0,0,0, PO1); sa(0,0,0,0,0, PO0R);
    sa(0,0,0,0,0, FL);  sa(0,0,0,0,0, FL);  sa(0,0,0,0,0, I0);
    // RET
    sa(1,2,0,0,0, ACC); sa(0,0,0,0,0, PO1); sa(0,0,0,0,0, PO0L);
    sa(0,0,0,0,0, FL);  sa(0,0,0,0,0, FL);  sa(0,0,0,0,0, I0);
    // irq pulse during CALL push: deferred until IDLE, then one interrupt entry
    sa(1,1,0,0,0, ACC); sa(0,0,0,0,1, PU0); sa(0,0,0,0,0, PU1L);
    sa(0,0,0,0,0, FL);  sa(0,0,0,0,0, FL);  sa(0,0,0,0,0, ACK);
    sa(0,0,0,0,0, PU0); sa(0,0,0,0,0, PU1V); sa(0,0,0,0,0, FL);
    sa(0,0,0,0,0, FL);  sa(0,0,0,0,0, I0);  sa(0,0,0,0,0, I0);
    // irq and CALL together: interrupt wins, CALL follows
    sa(1,1,0,0,1, ACK); sa(1,1,0,0,0, PU0); sa(1,1,0,0,0, PU1V);
    sa(1,1,0,0,0, FL);  sa(1,1,0,0,0, FL);  sa(1,1,0,0,0, ACC);
    sa(0,0,0,0,0, PU0); sa(0,0,0,0,0, PU1L); sa(0,0,0,0,0, FL);
    sa(0,0,0,0,0, FL);  sa(0,0,0,0,0, I0);
    // hold 3 cycles in POP cnt=0
    sa(1,2,0,0,0, ACC); sa(0,0,0,1,0, HPO1); sa(0,0,0,1,0, HPO1);
    sa(0,0,0,1,0, HPO1); sa(0,0,0,0,0, PO1); sa(0,0,0,0,0, PO0L);
    sa(0,0,0,0,0, FL);  sa(0,0,0,0,0, FL);  sa(0,0,0,0,0, I0);
    // hold during FLUSH freezes the flush counter
    sa(1,1,0,0,0, ACC); sa(0,0,0,0,0, PU0); sa(0,0,0,0,0, PU1L);
    sa(0,0,0,1,0, FL);  sa(0,0,0,1,0, FL);  sa(0,0,0,0,0, FL);
    sa(0,0,0,0,0, FL);  sa(0,0,0,0,0, I0);
    // irq under hold in IDLE is remembered, taken once hold drops
    sa(1,1,0,1,1, I0);  sa(0,0,0,0,0, ACK); sa(0,0,0,0,0, PU0);
    sa(0,0,0,0,0, PU1V); sa(0,0,0,0,0, FL); sa(0,0,0,0,0, FL);
    sa(0,0,0,0,0, I0);
    // bubble blocks, other class ignored, LDM single imm cycle
    sa(1,1,1,0,0, I0);  sa(1,5,0,0,0, I0);  sa(1,0,0,0,0, I0);
    sa(1,4,0,0,0, ACC); sa(0,0,0,0,0, IMMV); sa(0,0,0,0,0, I0);

    // 48-bit PC, no flush
    sb(1,0,0, I0);
    sb(1,1,1, ACC); sb(1,0,0, PU0); sb(1,0,0, BPU1); sb(1,0,0, BPU2L);
    sb(1,0,0, I0);
    // RET aborted by reset at POP idx=1
    sb(1,1,2, ACC); sb(1,0,0, BPO2); sb(0,0,0, I0); sb(1,0,0, I0);
    sb(1,1,4, ACC); sb(1,0,0, IMMV); sb(1,0,0, I0);

    @(negedge clk);
    #1;
    if (qa.size() != 0 || qb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d/%0d expected vectors left unchecked, want 0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Parametrised, stateful successor to the decode-stage control logic for multi-cycle instructions: CALL, RET, RTI, LDM and hardware interrupt entry. An explicit FSM replaces the pipelined firstTime*/St/Sst/FlushNum side-band bits. Sits in the decode stage beside the combinational control unit and overrides its per-cycle signals while busy. Generalised to any PC width split into stack words, and to any flush depth; adds deferred (pending) interrupts and a pipeline hold.

Parameters:
PC_W, 32, program-counter width in bits
STK_W, 16, stack/memory word width; WORDS = PC_W/STK_W (integer, >=1)
FLUSH_CYC, 2, squash cycles after a PC redirect (0 allowed)
IDX_W, 1, width of word_idx; must be >= clog2(WORDS), minimum 1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
instr_valid  in  1  decoded instruction present
op_class  in  3  0=other, 1=CALL, 2=RET, 3=RTI, 4=LDM, 5-7=other
bubble  in  1  hazard bubble; blocks acceptance only
hold  in  1  pipeline freeze; FSM holds state and counters
irq  in  1  interrupt request, level, sampled every edge
busy  out  1  FSM not in IDLE (decode/fetch stall)
accept  out  1  multi-cycle instruction taken this cycle
push_en  out  1  push one stack word
pop_en  out  1  pop one stack word
word_idx  out  IDX_W  stack word index being pushed/popped
pc_load  out  1  load PC (target/popped/vector) this cycle
vector_sel  out  1  with pc_load: PC source is interrupt vector (address 0)
save_ccr  out  1  freeze CCR into shadow (interrupt entry)
restore_ccr  out  1  restore CCR from shadow (RTI)
imm_phase  out  1  LDM immediate word cycle: write Rdst via ALU_MOV
flush  out  1  squash younger instructions
irq_ack  out  1  interrupt taken (1-cycle pulse)

Behaviour:
- States: IDLE, PUSH, POP, IMM, FLUSH. Registers: state, cnt (IDX_W), fcnt (clog2(FLUSH_CYC+1)), mode (CALL/INT/RET/RTI), irq_pend.
- Reset (async, rst_n=0): state=IDLE, cnt=0, fcnt=0, irq_pend=0; all outputs 0.
- Outputs are Moore (decoded from state/counters), except accept, irq_ack and save_ccr, which are IDLE-cycle decodes. When hold=1, push_en, pop_en, pc_load, restore_ccr and imm_phase are forced to 0 and nothing advances. busy and flush still reflect state.
- irq_pend sets on irq=1 in any state and clears when taken. Interrupts are never lost and never nest into a running sequence.
- IDLE priority, each evaluated with hold=0:
  1. irq_pend|irq: irq_ack=1, save_ccr=1, mode=INT -> PUSH, cnt=0.
  2. Else bubble: stay.
  3. Else instr_valid with class CALL: -> PUSH. RET: -> POP. RTI: -> POP. LDM: -> IMM. accept=1 for all four.
  4. Other classes stay in IDLE with accept=0.
- PUSH: push_en=1, word_idx=cnt (low word first, 0..WORDS-1). CALL pushes PC+1; INT pushes current PC. When cnt=WORDS-1: pc_load=1 (vector_sel=1 if INT), then -> FLUSH, or -> IDLE if FLUSH_CYC=0. Otherwise cnt+1.
- POP: pop_en=1, word_idx=WORDS-1-cnt (reverse of push order). Last word: pc_load=1; restore_ccr=1 if RTI; -> FLUSH/IDLE as above.
- IMM: exactly 1 cycle, imm_phase=1 -> IDLE. No flush.
- FLUSH: flush=1 for FLUSH_CYC cycles (fcnt down-counts), then -> IDLE. The instruction in IDLE may be accepted on the following edge.
- Latency from the accept/irq_ack cycle: CALL/INT/RET/RTI busy for WORDS+FLUSH_CYC cycles; LDM busy for 1 cycle.
- WORDS=1: PUSH/POP last exactly one cycle with word_idx=0.
- rst_n asserted mid-sequence aborts immediately. No partial pc_load is issued.

Test Plan:
- Defaults, CALL accepted at cycle 0 -> c1: push_en, idx=0; c2: push_en, idx=1, pc_load; c3-c4: flush; c5: busy=0.
- RTI -> c1: pop_en, idx=1; c2: pop_en, idx=0, pc_load, restore_ccr; 2 flush cycles. RET is identical with restore_ccr=0.
- irq 1-cycle pulse during CALL PUSH -> ignored until IDLE; then irq_ack, save_ccr, 2 pushes, pc_load with vector_sel=1. Exactly one ack.
- irq and CALL both valid in IDLE -> interrupt wins, accept=0; CALL taken after the interrupt sequence completes.
- hold=1 for 3 cycles in POP at cnt=0 -> pop_en=0 and state/idx frozen; resumes idx=1 with no pop lost or duplicated. LDM -> single imm_phase cycle.
- PC_W=48, FLUSH_CYC=0: CALL -> pushes idx 0,1,2, pc_load on the third push, busy ends with no flush. rst_n low at POP idx=1 -> all outputs 0 immediately, IDLE.
